riscv_mmio_ports: RTL and testbench

Parametrised memory-mapped I/O block for the single-cycle RISC-V core. It replaces the fixed single-word INPUT/OUTPUT pins with N_IN buffered input channels and N_OUT FIFO-backed output channels, each with a valid/ready handshake. It sits on the core's data-memory bus beside the data RAM and decodes a 256-byte window at BASE_ADDR.

---
 rtl/riscv_mmio_ports.sv | 206 ++++++++++++++++++++
 tb/tb_riscv_mmio_ports.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_mmio_ports.sv
// riscv_mmio_ports: memory-mapped I/O window for the single-cycle RISC-V core.
// N_IN single-entry input channels and N_OUT FIFO-backed output channels,
// each with a valid/ready handshake, decoded in a 256-byte window at BASE_ADDR.
// Optional feature macro: RISCV_MMIO_IRQ_EN (IRQ_MASK register and a
// registered level interrupt). Without it irq is tied low and IRQ_MASK reads 0.
module riscv_mmio_ports #(
  parameter int          DATA_W     = 32,
  parameter int          N_IN       = 2,
  parameter int          N_OUT      = 2,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_1000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [31:0]             bus_addr,
  input  logic [31:0]             bus_wdata,
  input  logic                    bus_we,
  input  logic                    bus_re,
  output logic                    bus_hit,
  output logic [31:0]             bus_rdata,
  input  logic [N_IN*DATA_W-1:0]  in_data,
  input  logic [N_IN-1:0]         in_valid,
  output logic [N_IN-1:0]         in_ready,
  output logic [N_OUT*DATA_W-1:0] out_data,
  output logic [N_OUT-1:0]        out_valid,
  input  logic [N_OUT-1:0]        out_ready,
  output logic                    irq
);

  localparam int         PW         = $clog2(FIFO_DEPTH);
  localparam int         CW         = PW + 1;
  localparam logic [5:0] IDX_OUT    = 6'd16;
  localparam logic [5:0] IDX_STATUS = 6'd32;
  localparam logic [5:0] IDX_MASK   = 6'd33;

  // Bus decode: word-aligned accesses inside the window only.
  logic       aligned;
  logic [5:0] word_idx;
  logic       wr_en;
  logic       rd_en;

  assign bus_hit  = (bus_addr[31:8] == BASE_ADDR[31:8]);
  assign aligned  = (bus_addr[1:0] == 2'b00);
  assign word_idx = bus_addr[7:2];
  assign wr_en    = bus_hit && aligned && bus_we;
  // A load that coincides with a store keeps its data but loses its side effect.
  assign rd_en    = bus_hit && aligned && bus_re && !bus_we;

  // Input channel state.
  logic [DATA_W-1:0] hold_q [N_IN];
  logic [N_IN-1:0]   full_q;

  // Output channel status gathered from the FIFO generate loop.
  logic [N_OUT-1:0]  out_full;
  logic [N_OUT-1:0]  push_rej;

  // Sticky overflow and optional mask.
  logic              ovf_q;
  logic              ovf_clr;
  logic [15:0]       mask_rd;

  assign in_ready = ~full_q & {N_IN{!rst}};

  // Input holding registers: capture on handshake, clear on a load of IN_DATA[i].
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q <= '0;
      for (int i = 0; i < N_IN; i++) begin
        hold_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_IN; i++) begin
        if (in_valid[i] && !full_q[i]) begin
          hold_q[i] <= in_data[i*DATA_W +: DATA_W];
          full_q[i] <= 1'b1;
        end else if (rd_en && (word_idx == 6'(i)) && full_q[i]) begin
          full_q[i] <= 1'b0;
        end
      end
    end
  end

  // Output FIFOs, one per channel.
  for (genvar j = 0; j < N_OUT; j++) begin : g_out
    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [DATA_W-1:0] last_q;
    logic [PW-1:0]     rd_q;
    logic [PW-1:0]     wr_q;
    logic [CW-1:0]     cnt_q;
    logic              push_req;
    logic              push;
    logic              pop;

    assign push_req    = wr_en && (word_idx == IDX_OUT + 6'(j));
    assign pop         = (cnt_q != '0) && out_ready[j];
    assign push        = push_req && ((cnt_q != CW'(FIFO_DEPTH)) || pop);
    assign push_rej[j] = push_req && !push;
    assign out_valid[j] = (cnt_q != '0);
    assign out_full[j]  = (cnt_q == CW'(FIFO_DEPTH));
    // When empty, present the last word that left so the head does not glitch.
    assign out_data[j*DATA_W +: DATA_W] = out_valid[j] ? mem_q[rd_q] : last_q;

    // FIFO storage; only ever read while the slot holds a pushed word.
    always_ff @(posedge clk) begin
      if (push) begin
        mem_q[wr_q] <= bus_wdata[DATA_W-1:0];
      end
    end

    // FIFO pointers, occupancy and last-popped word.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rd_q   <= '0;
        wr_q   <= '0;
        cnt_q  <= '0;
        last_q <= '0;
      end else begin
        if (push) begin
          wr_q <= wr_q + PW'(1);
        end
        if (pop) begin
          rd_q   <= rd_q + PW'(1);
          last_q <= mem_q[rd_q];
        end
        case ({push, pop})
          2'b10:   cnt_q <= cnt_q + CW'(1);
          2'b01:   cnt_q <= cnt_q - CW'(1);
          default: cnt_q <= cnt_q;
        endcase
      end
    end
  end

  assign ovf_clr = wr_en && (word_idx == IDX_STATUS) && bus_wdata[31];

  // Sticky overflow: a rejected push wins over a same-cycle clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (|push_rej) begin
      ovf_q <= 1'b1;
    end else if (ovf_clr) begin
      ovf_q <= 1'b0;
    end
  end

`ifdef RISCV_MMIO_IRQ_EN
  logic [15:0] mask_q;
  logic        irq_q;

  // Interrupt mask register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mask_q <= '0;
    end else if (wr_en && (word_idx == IDX_MASK)) begin
      mask_q <= bus_wdata[15:0];
    end
  end

  // Registered interrupt: follows its cause by one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= (|(full_q & mask_q[N_IN-1:0])) | (ovf_q & mask_q[15]);
    end
  end

  assign irq     = irq_q;
  assign mask_rd = mask_q;
`else
  assign irq     = 1'b0;
  assign mask_rd = '0;
`endif

  // Status fields zero-padded to 16 bits.
  logic [15:0] in_full16;
  logic [15:0] out_full16;

  // Widen per-channel flags into the fixed STATUS layout.
  always_comb begin
    in_full16               = '0;
    out_full16              = '0;
    in_full16[N_IN-1:0]     = full_q;
    out_full16[N_OUT-1:0]   = out_full;
  end

  // Combinational load data.
  always_comb begin
    bus_rdata = '0;
    if (bus_hit && aligned) begin
      for (int i = 0; i < N_IN; i++) begin
        if (word_idx == 6'(i)) begin
          bus_rdata[DATA_W-1:0] = hold_q[i];
        end
      end
      if (word_idx == IDX_STATUS) begin
        bus_rdata = {ovf_q, out_full16[14:0], in_full16};
      end
      if (word_idx == IDX_MASK) begin
        bus_rdata = {16'h0000, mask_rd};
      end
    end
  end

endmodule

// File: tb/tb_riscv_mmio_ports.sv
// Scoreboard bench for riscv_mmio_ports: stimulus tasks push expected load
// data; a negedge monitor compares DUT outputs against a queue-based model.
module tb_riscv_mmio_ports;

  localparam int          DW   = 16;
  localparam int          NI   = 2;
  localparam int          NO   = 2;
  localparam int          DEP  = 4;
  localparam logic [31:0] BASE = 32'h0000_1000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [31:0]   bus_addr = '0;
  logic [31:0]   bus_wdata = '0;
  logic          bus_we = 1'b0;
  logic          bus_re = 1'b0;
  logic          bus_hit;
  logic [31:0]   bus_rdata;
  logic [NI*DW-1:0] in_data = '0;
  logic [NI-1:0] in_valid = '0;
  logic [NI-1:0] in_ready;
  logic [NO*DW-1:0] out_data;
  logic [NO-1:0] out_valid;
  logic [NO-1:0] out_ready = '0;
  logic          irq;

  riscv_mmio_ports #(
    .DATA_W(DW), .N_IN(NI), .N_OUT(NO), .FIFO_DEPTH(DEP), .BASE_ADDR(BASE)
  ) dut (
    .clk(clk), .rst(rst),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_we(bus_we), .bus_re(bus_re),
    .bus_hit(bus_hit), .bus_rdata(bus_rdata),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .irq(irq)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [DW-1:0] hold_m [NI];
  logic [NI-1:0] full_m;
  logic [DW-1:0] last_m [NO];
  logic [DW-1:0] outq [NO][$];
  logic          ovf_m;
  logic [15:0]   mask_m;
  logic          irq_m;
  logic [31:0]   rd_exp [$];

  function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    full_m = '0;
    ovf_m  = 1'b0;
    mask_m = '0;
    irq_m  = 1'b0;
    for (int i = 0; i < NI; i++) hold_m[i] = '0;
    for (int j = 0; j < NO; j++) begin
      last_m[j] = '0;
      outq[j].delete();
    end
    rd_exp.delete();
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    logic [31:0] r;
    int w;
    r = '0;
    if (a[31:8] != BASE[31:8] || a[1:0] != 2'b00) return r;
    w = int'(a[7:2]);
    if (w < NI) begin
      r = {16'h0, hold_m[w]};
    end else if (w == 32) begin
      for (int i = 0; i < NI; i++) r[i] = full_m[i];
      for (int j = 0; j < NO; j++) r[16+j] = (outq[j].size() == DEP);
      r[31] = ovf_m;
    end else if (w == 33) begin
`ifdef RISCV_MMIO_IRQ_EN
      r = {16'h0, mask_m};
`endif
    end
    return r;
  endfunction

  // Monitor: compare the current cycle, then advance the model across the coming edge.
  always @(negedge clk) begin
    logic [NI-1:0] exp_rdy;
    logic          irq_nx;
    logic          ok_addr;
    logic          ovf_set;
    logic          ovf_clr;
    int            w;
    if (!rst) begin
      exp_rdy = ~full_m;
      chk("in_ready", {30'b0, in_ready}, {30'b0, exp_rdy});
      chk("bus_hit", {31'b0, bus_hit}, {31'b0, bus_addr[31:8] == BASE[31:8]});
      chk("irq", {31'b0, irq}, {31'b0, irq_m});
      for (int j = 0; j < NO; j++) begin
        chk($sformatf("out_valid%0d", j), {31'b0, out_valid[j]}, {31'b0, outq[j].size() != 0});
        if (outq[j].size() != 0)
          chk($sformatf("out_data%0d", j), {16'h0, out_data[j*DW +: DW]}, {16'h0, outq[j][0]});
        else
          chk($sformatf("out_hold%0d", j), {16'h0, out_data[j*DW +: DW]}, {16'h0, last_m[j]});
      end
      if (bus_re) begin
        if (rd_exp.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL rd_queue: load seen with no expectation, got %h", bus_rdata);
        end else begin
          chk("bus_rdata", bus_rdata, rd_exp.pop_front());
        end
      end

`ifdef RISCV_MMIO_IRQ_EN
      irq_nx = (|(full_m & mask_m[NI-1:0])) | (ovf_m & mask_m[15]);
`else
      irq_nx = 1'b0;
`endif
      ok_addr = (bus_addr[31:8] == BASE[31:8]) && (bus_addr[1:0] == 2'b00);
      w = int'(bus_addr[7:2]);
      for (int j = 0; j < NO; j++)
        if (outq[j].size() != 0 && out_ready[j]) last_m[j] = outq[j].pop_front();
      for (int i = 0; i < NI; i++) begin
        if (in_valid[i] && !full_m[i]) begin
          hold_m[i] = in_data[i*DW +: DW];
          full_m[i] = 1'b1;
        end else if (bus_re && !bus_we && ok_addr && w == i) begin
          full_m[i] = 1'b0;
        end
      end
      ovf_set = 1'b0;
      ovf_clr = 1'b0;
      if (bus_we && ok_addr) begin
        if (w >= 16 && w < 16 + NO) begin
          if (outq[w-16].size() < DEP) outq[w-16].push_back(bus_wdata[DW-1:0]);
          else ovf_set = 1'b1;
        end
        if (w == 32 && bus_wdata[31]) ovf_clr = 1'b1;
        if (w == 33) mask_m = bus_wdata[15:0];
      end
      if (ovf_set) ovf_m = 1'b1;
      else if (ovf_clr) ovf_m = 1'b0;
      irq_m = irq_nx;
    end
  end

  // All stimulus tasks start and end at posedge + 1.
  task automatic bus_op(input logic we, input logic re, input logic [31:0] a, input logic [31:0] d);
    bus_we = we; bus_re = re; bus_addr = a; bus_wdata = d;
    if (re) rd_exp.push_back(model_read(a));
    @(posedge clk); #1;
    bus_we = 1'b0; bus_re = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic mid_reset();
    rst = 1'b1;
    #1;
    chk("rst_out_valid", {30'b0, out_valid}, 32'd0);
    chk("rst_in_ready", {30'b0, in_ready}, 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_irq", {31'b0, irq}, 32'd0);
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int vals [4] = '{20, 25, 15, 40};
  int op;
  logic expect_irq;

  initial begin
    model_reset();
    #50;
    chk("reset_in_ready", {30'b0, in_ready}, 32'd0);
    #50 rst = 1'b0;
    @(posedge clk); #1;
    chk("post_reset_in_ready", {30'b0, in_ready}, 32'd3);
    chk("post_reset_out_valid", {30'b0, out_valid}, 32'd0);
    chk("post_reset_irq", {31'b0, irq}, 32'd0);
    bus_op(0, 1, BASE + 32'h80, 0);

    // Input channel 0 capture and clearing loads
    foreach (vals[k]) begin
      in_data[DW-1:0] = DW'(vals[k]);
      in_valid[0] = 1'b1;
      idle(1);
      in_valid[0] = 1'b0;
      idle(1);
      chk("in_full_set", {31'b0, in_ready[0]}, 32'd0);
      bus_op(0, 1, BASE, 0);
      chk("in_full_clr", {31'b0, in_ready[0]}, 32'd1);
      bus_op(0, 1, BASE, 0);
    end

    // Fill FIFO 0, overflow, then drain
    out_ready = '0;
    for (int k = 1; k <= 4; k++) bus_op(1, 0, BASE + 32'h40, k);
    bus_op(0, 1, BASE + 32'h80, 0);
    bus_op(1, 0, BASE + 32'h40, 5);
    bus_op(0, 1, BASE + 32'h80, 0);
    out_ready[0] = 1'b1;
    idle(4);
    chk("drained_valid", {31'b0, out_valid[0]}, 32'd0);
    chk("drained_hold", {16'h0, out_data[DW-1:0]}, 32'd4);
    bus_op(1, 0, BASE + 32'h80, 32'h8000_0000);
    bus_op(0, 1, BASE + 32'h80, 0);

    // Push into a full FIFO while it pops
    out_ready = '0;
    for (int k = 11; k <= 14; k++) bus_op(1, 0, BASE + 32'h40, k);
    out_ready[0] = 1'b1;
    bus_op(1, 0, BASE + 32'h40, 9);
    out_ready[0] = 1'b0;
    bus_op(0, 1, BASE + 32'h80, 0);
    out_ready[0] = 1'b1;
    idle(5);
    chk("wrap_hold", {16'h0, out_data[DW-1:0]}, 32'd9);

    // Interrupt from a masked input channel
    bus_op(1, 0, BASE + 32'h84, 1);
    bus_op(0, 1, BASE + 32'h84, 0);
    in_data[DW-1:0] = 16'h0077;
    in_valid[0] = 1'b1;
    idle(1);
    in_valid[0] = 1'b0;
    idle(2);
`ifdef RISCV_MMIO_IRQ_EN
    expect_irq = 1'b1;
`else
    expect_irq = 1'b0;
`endif
    chk("irq_raised", {31'b0, irq}, {31'b0, expect_irq});
    bus_op(0, 1, BASE, 0);
    idle(2);
    chk("irq_cleared", {31'b0, irq}, 32'd0);
    bus_op(1, 0, BASE + 32'h84, 0);

    // Reset with two words queued on channel 1
    out_ready = '0;
    bus_op(1, 0, BASE + 32'h44, 16'hAAAA);
    bus_op(1, 0, BASE + 32'h44, 16'h5555);
    chk("pre_reset_valid", {31'b0, out_valid[1]}, 32'd1);
    mid_reset();
    chk("post_mid_reset_valid", {30'b0, out_valid}, 32'd0);
    bus_op(0, 1, BASE + 32'h80, 0);

    // Randomised traffic
    repeat (600) begin
      in_valid  = NI'($urandom);
      in_data   = NI*DW'($urandom);
      out_ready = NO'($urandom_range(0, 3));
      op = $urandom_range(0, 11);
      case (op)
        0, 1, 2: bus_op(0, 0, BASE, 0);
        3, 4:    bus_op(0, 1, BASE + 32'($urandom_range(0, NI-1) * 4), 0);
        5:       bus_op(0, 1, BASE + 32'($urandom_range(0, 255)), 0);
        6, 7:    bus_op(1, 0, BASE + 32'h40 + 32'($urandom_range(0, NO-1) * 4), $urandom);
        8:       bus_op(1, 0, BASE + (($urandom_range(0, 1) != 0) ? 32'h80 : 32'h84), $urandom);
        9:       bus_op(1, 1, BASE + 32'($urandom_range(0, NI-1) * 4), $urandom);
        10:      bus_op(1, 1, BASE + 32'h40 + 32'($urandom_range(0, NO-1) * 4), $urandom);
        default: bus_op(0, 1, BASE + 32'h100 + 32'($urandom_range(0, 63) * 4), 0);
      endcase
    end

    in_valid  = '0;
    out_ready = '1;
    idle(8);
    chk("rd_queue_drained", rd_exp.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
